load_unit: RTL and testbench
============================

// Module: load_unit
// PURPOSE
//  Load execution stage, directly downstream of the load buffer. Pops one ready load
//  per transaction, generates the effective address (base + offset), and performs
//  a valid/ready request + valid response handshake with the data-memory port.
//  Broadcasts the loaded value with its ROB and physical-register tags on the
//  writeback bus. Only one load is in flight at a time; honours pipeline flush.
// PARAMETERS
//  XLEN           16   data/address width
//  ROB_ADDR_W     4    ROB index width
//  PREG_ADDR_W    5    physical register index width
//  TIMEOUT_CYCLES 64   response watchdog limit (LOAD_UNIT_TIMEOUT_EN only)
// PORTS
//  clk            in   1            clock, rising edge
//  n_rst          in   1            asynchronous active-low reset
//  lb_ready       in   1            load buffer holds an issuable load
//  lb_base        in   XLEN         base operand of that load
//  lb_offset      in   XLEN         immediate offset of that load
//  lb_rob_addr    in   ROB_ADDR_W   ROB tag of that load
//  lb_dst         in   PREG_ADDR_W  destination physical register
//  lb_pop         out  1            load accepted; buffer frees entry this edge
//  flush          in   1            squash all in-flight work
//  mem_req_valid  out  1            memory read request valid
//  mem_req_ready  in   1            memory accepts request
//  mem_req_addr   out  XLEN         request address
//  mem_resp_valid in   1            read data valid
//  mem_resp_data  in   XLEN         read data
//  wb_valid       out  1            writeback broadcast valid (1-cycle pulse)
//  wb_rob_addr    out  ROB_ADDR_W   writeback ROB tag
//  wb_preg        out  PREG_ADDR_W  writeback destination register
//  wb_data        out  XLEN         writeback value
//  busy           out  1            state != IDLE
//  fault          out  1            sticky watchdog fault (tied 0 without macro)
// BEHAVIOUR
//  - Reset (async, n_rst=0): state=IDLE; all outputs 0; captured tags/addr/data 0.
//  - FSM states: IDLE, REQ, WAIT, WB, DRAIN.
//  - IDLE: lb_pop = lb_ready & ~flush (combinational). On pop: latch
//    addr = (lb_base + lb_offset) mod 2^XLEN (carry dropped), lb_rob_addr, lb_dst -> REQ.
//  - REQ: mem_req_valid=1, mem_req_addr stable until accepted. mem_req_ready=1 -> WAIT.
//  - WAIT: on mem_resp_valid latch mem_resp_data -> WB.
//  - WB: wb_valid = ~flush for exactly one cycle; tags/data from latches -> IDLE.
//    No pop in the WB cycle (next pop earliest in following IDLE cycle).
//  - Best-case latency: pop edge 0, req cycle 1 (ready=1), resp cycle 2, wb_valid cycle 3.
//  - mem_resp_valid outside WAIT/DRAIN is ignored.
//  - Flush: IDLE -> no pop; REQ with mem_req_ready=0 -> IDLE (request withdrawn);
//    REQ with mem_req_ready=1 same cycle -> request counts as issued -> DRAIN;
//    WAIT -> DRAIN (or IDLE if mem_resp_valid same cycle); WB -> wb_valid suppressed, IDLE.
//  - DRAIN: wait for mem_resp_valid, discard data, no writeback -> IDLE. flush in DRAIN no effect.
//  - wb_* tag/data outputs hold last value when wb_valid=0.
// CONFIGURATION
//  LOAD_UNIT_TIMEOUT_EN defined: counter cleared on entry to WAIT/DRAIN, increments each
//   cycle there without mem_resp_valid; on reaching TIMEOUT_CYCLES: fault=1 (sticky until
//   n_rst), FSM -> IDLE, no writeback; later stray responses ignored; pops continue.
//  Not defined: no counter, fault tied 0, WAIT/DRAIN wait indefinitely.
// TESTING
//  1 base=0x0010 offset=0x0004, ready=1 always, resp data 0xBEEF next cycle -> req addr
//    0x0014 cycle 1, wb_valid cycle 3, wb_data 0xBEEF, tags match lb_rob_addr/lb_dst.
//  2 base=0xFFFE offset=0x0005 -> mem_req_addr=0x0003 (wrap, carry dropped).
//  3 mem_req_ready low 5 cycles -> mem_req_valid high, addr stable all 5; one pop total.
//  4 flush in WAIT, response 2 cycles later -> no wb_valid; busy until response; next pop after.
//  5 flush with mem_req_ready=1 same cycle in REQ -> DRAIN, response swallowed, no wb.
//  6 (TIMEOUT_EN) no response 64 cycles -> fault=1, busy=0; later pop/resp completes normally.

Source files
------------

// File: rtl/load_unit.sv
// Load execution stage: pops one load from the load buffer, forms base + offset,
// runs a single-outstanding request/response exchange with the data-memory port and
// broadcasts the result on the writeback bus. Optional response watchdog is enabled
// by defining LOAD_UNIT_TIMEOUT_EN.
module load_unit #(
    parameter int unsigned XLEN           = 16,
    parameter int unsigned ROB_ADDR_W     = 4,
    parameter int unsigned PREG_ADDR_W    = 5,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   lb_ready,
    input  logic [XLEN-1:0]        lb_base,
    input  logic [XLEN-1:0]        lb_offset,
    input  logic [ROB_ADDR_W-1:0]  lb_rob_addr,
    input  logic [PREG_ADDR_W-1:0] lb_dst,
    output logic                   lb_pop,
    input  logic                   flush,
    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic [XLEN-1:0]        mem_req_addr,
    input  logic                   mem_resp_valid,
    input  logic [XLEN-1:0]        mem_resp_data,
    output logic                   wb_valid,
    output logic [ROB_ADDR_W-1:0]  wb_rob_addr,
    output logic [PREG_ADDR_W-1:0] wb_preg,
    output logic [XLEN-1:0]        wb_data,
    output logic                   busy,
    output logic                   fault
);

    typedef enum logic [2:0] {StIdle, StReq, StWait, StWb, StDrain} state_e;

    state_e                 state_q, state_d;
    logic [XLEN-1:0]        addr_q, addr_d;
    logic [ROB_ADDR_W-1:0]  rob_q, rob_d;
    logic [PREG_ADDR_W-1:0] preg_q, preg_d;
    // Writeback fields are separate registers so they hold across the next pop.
    logic [ROB_ADDR_W-1:0]  wb_rob_q, wb_rob_d;
    logic [PREG_ADDR_W-1:0] wb_preg_q, wb_preg_d;
    logic [XLEN-1:0]        wb_data_q, wb_data_d;

`ifdef LOAD_UNIT_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            fault_q, fault_d;
    logic            waiting;
`endif

    // Next-state and handshake outputs.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        rob_d         = rob_q;
        preg_d        = preg_q;
        wb_rob_d      = wb_rob_q;
        wb_preg_d     = wb_preg_q;
        wb_data_d     = wb_data_q;
        lb_pop        = 1'b0;
        mem_req_valid = 1'b0;
        wb_valid      = 1'b0;
`ifdef LOAD_UNIT_TIMEOUT_EN
        cnt_d         = cnt_q;
        fault_d       = fault_q;
        waiting       = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                if (lb_ready && !flush) begin
                    lb_pop  = 1'b1;
                    addr_d  = lb_base + lb_offset;
                    rob_d   = lb_rob_addr;
                    preg_d  = lb_dst;
                    state_d = StReq;
                end
            end
            StReq: begin
                mem_req_valid = 1'b1;
                // An accepted request must be drained even when flushed.
                if (mem_req_ready) begin
                    state_d = flush ? StDrain : StWait;
                end else if (flush) begin
                    state_d = StIdle;
                end
            end
            StWait: begin
                if (mem_resp_valid) begin
                    if (flush) begin
                        state_d = StIdle;
                    end else begin
                        wb_data_d = mem_resp_data;
                        wb_rob_d  = rob_q;
                        wb_preg_d = preg_q;
                        state_d   = StWb;
                    end
                end else if (flush) begin
                    state_d = StDrain;
                end
            end
            StWb: begin
                wb_valid = !flush;
                state_d  = StIdle;
            end
            StDrain: begin
                if (mem_resp_valid) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
`ifdef LOAD_UNIT_TIMEOUT_EN
        waiting = ((state_q == StWait) || (state_q == StDrain)) && !mem_resp_valid;
        if (waiting && (cnt_q == CntW'(TIMEOUT_CYCLES - 1))) begin
            state_d = StIdle;
            fault_d = 1'b1;
        end
        if (((state_d == StWait) || (state_d == StDrain)) && (state_d != state_q)) begin
            cnt_d = '0;
        end else if (waiting) begin
            cnt_d = cnt_q + CntW'(1);
        end
`endif
    end

    // State and captured operands.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            rob_q     <= '0;
            preg_q    <= '0;
            wb_rob_q  <= '0;
            wb_preg_q <= '0;
            wb_data_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rob_q     <= rob_d;
            preg_q    <= preg_d;
            wb_rob_q  <= wb_rob_d;
            wb_preg_q <= wb_preg_d;
            wb_data_q <= wb_data_d;
        end
    end

`ifdef LOAD_UNIT_TIMEOUT_EN
    // Watchdog counter and sticky fault flag.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

    assign mem_req_addr = addr_q;
    assign wb_rob_addr  = wb_rob_q;
    assign wb_preg      = wb_preg_q;
    assign wb_data      = wb_data_q;
    assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_load_unit.sv
// Self-checking bench for load_unit: directed protocol/flush cases plus randomized loads
// checked against a transaction-level expectation (address = base + offset mod 2^16).
module tb_load_unit;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        lb_ready;
    logic [15:0] lb_base;
    logic [15:0] lb_offset;
    logic [3:0]  lb_rob_addr;
    logic [4:0]  lb_dst;
    logic        lb_pop;
    logic        flush;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [15:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [15:0] mem_resp_data;
    logic        wb_valid;
    logic [3:0]  wb_rob_addr;
    logic [4:0]  wb_preg;
    logic [15:0] wb_data;
    logic        busy;
    logic        fault;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] last_wb_data;

    load_unit dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .lb_ready       (lb_ready),
        .lb_base        (lb_base),
        .lb_offset      (lb_offset),
        .lb_rob_addr    (lb_rob_addr),
        .lb_dst         (lb_dst),
        .lb_pop         (lb_pop),
        .flush          (flush),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .wb_valid       (wb_valid),
        .wb_rob_addr    (wb_rob_addr),
        .wb_preg        (wb_preg),
        .wb_data        (wb_data),
        .busy           (busy),
        .fault          (fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance to 1ns after the next rising edge; inputs change here, checks 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] ea(input logic [15:0] base, input logic [15:0] off);
        int s;
        s = (int'(base) + int'(off)) % 65536;
        return 16'(s);
    endfunction

    // Pop a load in IDLE and leave the DUT in REQ.
    task automatic start_load(input logic [15:0] base, input logic [15:0] off,
                              input logic [3:0] rob, input logic [4:0] dst);
        lb_ready = 1'b1; lb_base = base; lb_offset = off; lb_rob_addr = rob; lb_dst = dst;
        flush = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        #1;
        check("start_pop", lb_pop, 1);
        tick();
        lb_ready = 1'b0;
    endtask

    // Full load with configurable request-stall and response-delay cycles.
    task automatic run_load(input logic [15:0] base, input logic [15:0] off,
                            input logic [3:0] rob, input logic [4:0] dst,
                            input logic [15:0] data, input int req_dly, input int resp_dly);
        int          pops;
        logic [15:0] exp_addr;
        exp_addr = ea(base, off);
        lb_ready = 1'b1; lb_base = base; lb_offset = off; lb_rob_addr = rob; lb_dst = dst;
        flush = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        #1;
        check("pop", lb_pop, 1);
        pops = int'(lb_pop);
        tick();
        // Keep offering new loads with different operands; none may be taken.
        lb_base = 16'($urandom); lb_offset = 16'($urandom);
        lb_rob_addr = 4'($urandom); lb_dst = 5'($urandom);
        for (int i = 0; i <= req_dly; i++) begin
            mem_req_ready = (i == req_dly);
            #1;
            check("req_valid", mem_req_valid, 1);
            check("req_addr", mem_req_addr, exp_addr);
            pops += int'(lb_pop);
            tick();
        end
        mem_req_ready = 1'b0;
        for (int i = 0; i <= resp_dly; i++) begin
            mem_resp_valid = (i == resp_dly);
            mem_resp_data  = (i == resp_dly) ? data : 16'($urandom);
            #1;
            check("wait_no_wb", wb_valid, 0);
            check("wait_busy", busy, 1);
            pops += int'(lb_pop);
            tick();
        end
        mem_resp_valid = 1'b0; mem_resp_data = 16'($urandom);
        #1;
        check("wb_valid", wb_valid, 1);
        check("wb_data", wb_data, data);
        check("wb_rob", wb_rob_addr, rob);
        check("wb_preg", wb_preg, dst);
        check("wb_no_pop", lb_pop, 0);
        pops += int'(lb_pop);
        tick();
        lb_ready = 1'b0;
        #1;
        check("after_busy", busy, 0);
        check("after_wb_pulse", wb_valid, 0);
        check("after_wb_hold", wb_data, data);
        check("one_pop", pops, 1);
        last_wb_data = data;
    endtask

    initial begin
        n_rst = 1'b0; lb_ready = 1'b0; lb_base = '0; lb_offset = '0; lb_rob_addr = '0;
        lb_dst = '0; flush = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        mem_resp_data = '0; last_wb_data = '0;
        #12;
        check("rst_busy", busy, 0);
        check("rst_req_valid", mem_req_valid, 0);
        check("rst_req_addr", mem_req_addr, 0);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_wb_fields", {wb_rob_addr, wb_preg, wb_data}, 0);
        check("rst_fault", fault, 0);
        check("rst_pop", lb_pop, 0);
        tick();
        n_rst = 1'b1;
        tick();

        // Best-case latency: pop cycle 0, req cycle 1, resp cycle 2, wb cycle 3.
        lb_ready = 1'b1; lb_base = 16'h0010; lb_offset = 16'h0004;
        lb_rob_addr = 4'h5; lb_dst = 5'h1A; mem_req_ready = 1'b1;
        #1;
        check("t1_pop", lb_pop, 1);
        tick();
        #1;
        check("t1_req_valid", mem_req_valid, 1);
        check("t1_req_addr", mem_req_addr, 16'h0014);
        check("t1_c1_pop", lb_pop, 0);
        tick();
        mem_resp_valid = 1'b1; mem_resp_data = 16'hBEEF;
        #1;
        check("t1_c2_req_valid", mem_req_valid, 0);
        check("t1_c2_wb", wb_valid, 0);
        tick();
        mem_resp_valid = 1'b0; mem_resp_data = 16'h0000;
        #1;
        check("t1_wb_valid", wb_valid, 1);
        check("t1_wb_data", wb_data, 16'hBEEF);
        check("t1_wb_rob", wb_rob_addr, 4'h5);
        check("t1_wb_preg", wb_preg, 5'h1A);
        check("t1_wb_no_pop", lb_pop, 0);
        tick();
        lb_ready = 1'b0; mem_req_ready = 1'b0;
        #1;
        check("t1_idle", busy, 0);
        check("t1_pulse", wb_valid, 0);
        check("t1_hold", wb_data, 16'hBEEF);
        last_wb_data = 16'hBEEF;

        // Address wrap and a 5-cycle request stall.
        run_load(16'hFFFE, 16'h0005, 4'h3, 5'h07, 16'h1357, 0, 0);
        run_load(16'h1200, 16'h0034, 4'hC, 5'h11, 16'hA5A5, 5, 1);

        // Flush in IDLE: nothing popped.
        lb_ready = 1'b1; flush = 1'b1;
        #1;
        check("fl_idle_pop", lb_pop, 0);
        tick();
        lb_ready = 1'b0; flush = 1'b0;
        #1;
        check("fl_idle_busy", busy, 0);

        // Flush in REQ without acceptance withdraws the request; stray response ignored.
        start_load(16'h0100, 16'h0001, 4'h1, 5'h01);
        flush = 1'b1;
        #1;
        check("fl_req_valid", mem_req_valid, 1);
        tick();
        flush = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 16'h7777;
        #1;
        check("fl_req_idle", busy, 0);
        check("fl_req_withdrawn", mem_req_valid, 0);
        tick();
        mem_resp_valid = 1'b0;
        #1;
        check("stray_busy", busy, 0);
        check("stray_wb", wb_valid, 0);
        check("stray_hold", wb_data, last_wb_data);

        // Flush with acceptance in the same cycle: response drained, no writeback.
        start_load(16'h0200, 16'h0002, 4'h2, 5'h02);
        flush = 1'b1; mem_req_ready = 1'b1;
        tick();
        flush = 1'b0; mem_req_ready = 1'b0;
        #1;
        check("t5_drain_busy", busy, 1);
        check("t5_drain_req", mem_req_valid, 0);
        mem_resp_valid = 1'b1; mem_resp_data = 16'h1234;
        tick();
        mem_resp_valid = 1'b0;
        #1;
        check("t5_idle", busy, 0);
        check("t5_no_wb", wb_valid, 0);
        check("t5_hold", wb_data, last_wb_data);

        // Flush in WAIT, response two cycles later; no pop until drained.
        start_load(16'h0300, 16'h0003, 4'h3, 5'h03);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0; lb_ready = 1'b1;
        #1;
        check("t4_drain_busy", busy, 1);
        check("t4_drain_pop", lb_pop, 0);
        tick();
        mem_resp_valid = 1'b1; mem_resp_data = 16'h4321;
        #1;
        check("t4_resp_pop", lb_pop, 0);
        check("t4_resp_wb", wb_valid, 0);
        tick();
        mem_resp_valid = 1'b0;
        #1;
        check("t4_idle", busy, 0);
        check("t4_no_wb", wb_valid, 0);
        check("t4_pop_again", lb_pop, 1);
        lb_ready = 1'b0;
        #1;
        check("t4_hold", wb_data, last_wb_data);

        // Flush in WAIT together with the response: straight back to IDLE.
        start_load(16'h0400, 16'h0004, 4'h4, 5'h04);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0; flush = 1'b1; mem_resp_valid = 1'b1;
        tick();
        flush = 1'b0; mem_resp_valid = 1'b0;
        #1;
        check("fl_wait_resp_idle", busy, 0);
        check("fl_wait_resp_wb", wb_valid, 0);

        // Flush in WB suppresses the broadcast.
        start_load(16'h0500, 16'h0005, 4'h5, 5'h05);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 16'h5555;
        tick();
        mem_resp_valid = 1'b0; flush = 1'b1;
        #1;
        check("fl_wb_suppress", wb_valid, 0);
        tick();
        flush = 1'b0;
        #1;
        check("fl_wb_idle", busy, 0);
        check("fl_wb_no_late", wb_valid, 0);

        // Randomized loads.
        for (int n = 0; n < 20; n++) begin
            run_load(16'($urandom), 16'($urandom), 4'($urandom), 5'($urandom),
                     16'($urandom), $urandom_range(0, 4), $urandom_range(0, 4));
        end

`ifdef LOAD_UNIT_TIMEOUT_EN
        // 64 response-less cycles in WAIT trip the watchdog.
        start_load(16'h0600, 16'h0006, 4'h6, 5'h06);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        for (int i = 0; i < 64; i++) begin
            #1;
            if (i == 63) begin
                check("to_pre_busy", busy, 1);
                check("to_pre_fault", fault, 0);
            end
            tick();
        end
        #1;
        check("to_fault", fault, 1);
        check("to_busy", busy, 0);
        check("to_no_wb", wb_valid, 0);
        mem_resp_valid = 1'b1; mem_resp_data = 16'hDEAD;
        tick();
        mem_resp_valid = 1'b0;
        #1;
        check("to_stray_busy", busy, 0);
        run_load(16'h0700, 16'h0007, 4'h7, 5'h07, 16'hCAFE, 1, 2);
        check("to_sticky", fault, 1);
`else
        // Without the watchdog a missing response is waited for indefinitely.
        start_load(16'h0600, 16'h0006, 4'h6, 5'h06);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        for (int i = 0; i < 80; i++) tick();
        #1;
        check("nto_busy", busy, 1);
        check("nto_fault", fault, 0);
        mem_resp_valid = 1'b1; mem_resp_data = 16'hCAFE;
        tick();
        mem_resp_valid = 1'b0;
        #1;
        check("nto_wb_valid", wb_valid, 1);
        check("nto_wb_data", wb_data, 16'hCAFE);
        check("nto_wb_rob", wb_rob_addr, 4'h6);
        tick();
        #1;
        check("nto_idle", busy, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
